// File: rtl/q_track_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : q_track_pkg
//  Description : Shared FSM state encoding and small arithmetic helpers for
//                the multi-channel Q regulator.
//  Revision    : 1.0 - initial release
// ============================================================================
package q_track_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_UPDATE = 3'd3,
        S_NEXT   = 3'd4
    } state_t;

    // Helpers run on zero-extended 32-bit operands so no intermediate wraps.
    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] max_val);
        return ((a + b) > max_val) ? max_val : (a + b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/q_track_step.sv
`default_nettype none
// ============================================================================
//  Module      : q_track_step
//  Description : Combinational per-channel regulator step: bisection search,
//                lock detection and instability re-open of the i_ref window.
//  Revision    : 1.0 - initial release
// ============================================================================
module q_track_step
    import q_track_pkg::*;
#(
    parameter int BUS_WIDTH         = 10,
    parameter int TOL               = 1,
    parameter int DELTA_Q_INSTB     = 50,
    parameter int I_REF_DELTA_INSTB = 10
) (
    input  logic [BUS_WIDTH-1:0] i_lo,
    input  logic [BUS_WIDTH-1:0] i_hi,
    input  logic [BUS_WIDTH-1:0] i_i_ref,
    input  logic [BUS_WIDTH-1:0] i_q_lock,
    input  logic                 i_locked,
    input  logic [BUS_WIDTH-1:0] i_q_meas,
    input  logic [BUS_WIDTH-1:0] i_q_des,
    output logic [BUS_WIDTH-1:0] o_lo_nxt,
    output logic [BUS_WIDTH-1:0] o_hi_nxt,
    output logic [BUS_WIDTH-1:0] o_i_ref_nxt,
    output logic [BUS_WIDTH-1:0] o_q_lock_nxt,
    output logic                 o_locked_nxt
);

    localparam logic [31:0] c_MAX = (32'd1 << BUS_WIDTH) - 32'd1;

    logic [31:0] w_lo_b;
    logic [31:0] w_hi_b;
    logic [31:0] w_sum;

    always_comb begin
        o_lo_nxt     = i_lo;
        o_hi_nxt     = i_hi;
        o_i_ref_nxt  = i_i_ref;
        o_q_lock_nxt = i_q_lock;
        o_locked_nxt = i_locked;
        w_lo_b       = 32'(i_lo);
        w_hi_b       = 32'(i_hi);
        w_sum        = 32'd0;
        if (!i_locked) begin
            if (abs_diff(32'(i_q_meas), 32'(i_q_des)) <= 32'(TOL)) begin
                o_locked_nxt = 1'b1;
                o_q_lock_nxt = i_q_meas;
            end else begin
                if (i_q_meas < i_q_des) begin
                    w_lo_b = 32'(i_i_ref);
                end else begin
                    w_hi_b = 32'(i_i_ref);
                end
                o_lo_nxt = BUS_WIDTH'(w_lo_b);
                o_hi_nxt = BUS_WIDTH'(w_hi_b);
                // Window collapsed: no better i_ref exists, so settle where we are.
                if (w_hi_b <= w_lo_b + 32'd1) begin
                    o_locked_nxt = 1'b1;
                    o_q_lock_nxt = i_q_meas;
                end else begin
                    w_sum       = w_lo_b + w_hi_b;
                    o_i_ref_nxt = BUS_WIDTH'(w_sum >> 1);
                end
            end
        end else if (abs_diff(32'(i_q_meas), 32'(i_q_lock)) > 32'(DELTA_Q_INSTB)) begin
            o_locked_nxt = 1'b0;
            w_lo_b       = sat_sub(32'(i_i_ref), 32'(I_REF_DELTA_INSTB));
            w_hi_b       = sat_add(32'(i_i_ref), 32'(I_REF_DELTA_INSTB), c_MAX);
            o_lo_nxt     = BUS_WIDTH'(w_lo_b);
            o_hi_nxt     = BUS_WIDTH'(w_hi_b);
        end
    end

endmodule
`default_nettype wire

// File: rtl/q_track_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : q_track_ctrl
//  Description : Round-robin multi-channel closed-loop Q regulator driving a
//                shared measurement front-end. Optional measurement timeout
//                and per-channel fault flags under Q_TRACK_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module q_track_ctrl
    import q_track_pkg::*;
#(
    parameter int BUS_WIDTH         = 10,
    parameter int NUM_CH            = 4,
    parameter int TOL               = 1,
    parameter int DELTA_Q_INSTB     = 50,
    parameter int I_REF_DELTA_INSTB = 10,
    parameter int WAIT_MAX          = 255,
    localparam int CH_W             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [NUM_CH*BUS_WIDTH-1:0] q_desired,
    output logic                        meas_start,
    output logic [CH_W-1:0]             meas_ch,
    input  logic                        ready,
    input  logic [BUS_WIDTH-1:0]        q_measured,
    output logic [NUM_CH*BUS_WIDTH-1:0] i_ref_out,
    output logic [NUM_CH-1:0]           setup_completed,
    output logic [NUM_CH-1:0]           fault
);

    localparam logic [BUS_WIDTH-1:0] c_MID  = {1'b1, {(BUS_WIDTH-1){1'b0}}};
    localparam logic [CH_W-1:0]      c_LAST = CH_W'(NUM_CH - 1);

    state_t               r_state;
    logic [CH_W-1:0]      r_ch;
    logic [BUS_WIDTH-1:0] r_q_meas;
    logic [BUS_WIDTH-1:0] r_lo    [NUM_CH];
    logic [BUS_WIDTH-1:0] r_hi    [NUM_CH];
    logic [BUS_WIDTH-1:0] r_iref  [NUM_CH];
    logic [BUS_WIDTH-1:0] r_qlock [NUM_CH];
    logic [NUM_CH-1:0]    r_locked;

    logic [BUS_WIDTH-1:0] w_lo_nxt;
    logic [BUS_WIDTH-1:0] w_hi_nxt;
    logic [BUS_WIDTH-1:0] w_iref_nxt;
    logic [BUS_WIDTH-1:0] w_qlock_nxt;
    logic                 w_locked_nxt;
    logic [CH_W-1:0]      w_ch_next;

`ifdef Q_TRACK_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(WAIT_MAX + 1);
    logic [c_CNT_W-1:0] r_wait_cnt;
    logic [NUM_CH-1:0]  r_fault;
    assign fault = r_fault;
`else
    assign fault = '0;
`endif

    assign w_ch_next = (r_ch == c_LAST) ? '0 : r_ch + 1'b1;

    // Single shared datapath, steered to the channel currently being visited.
    q_track_step #(
        .BUS_WIDTH         (BUS_WIDTH),
        .TOL               (TOL),
        .DELTA_Q_INSTB     (DELTA_Q_INSTB),
        .I_REF_DELTA_INSTB (I_REF_DELTA_INSTB)
    ) u_step (
        .i_lo         (r_lo[r_ch]),
        .i_hi         (r_hi[r_ch]),
        .i_i_ref      (r_iref[r_ch]),
        .i_q_lock     (r_qlock[r_ch]),
        .i_locked     (r_locked[r_ch]),
        .i_q_meas     (r_q_meas),
        .i_q_des      (q_desired[r_ch*BUS_WIDTH +: BUS_WIDTH]),
        .o_lo_nxt     (w_lo_nxt),
        .o_hi_nxt     (w_hi_nxt),
        .o_i_ref_nxt  (w_iref_nxt),
        .o_q_lock_nxt (w_qlock_nxt),
        .o_locked_nxt (w_locked_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ch       <= '0;
            meas_start <= 1'b0;
            meas_ch    <= '0;
            r_q_meas   <= '0;
            r_locked   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_lo[i]    <= '0;
                r_hi[i]    <= '1;
                r_iref[i]  <= c_MID;
                r_qlock[i] <= '0;
            end
`ifdef Q_TRACK_TIMEOUT_EN
            r_wait_cnt <= '0;
            r_fault    <= '0;
`endif
        end else begin
            meas_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state    <= S_REQ;
                        meas_start <= 1'b1;
                        meas_ch    <= r_ch;
                    end
                end
                S_REQ: begin
                    r_state <= S_WAIT;
`ifdef Q_TRACK_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (ready) begin
                        r_q_meas <= q_measured;
                        r_state  <= S_UPDATE;
`ifdef Q_TRACK_TIMEOUT_EN
                        r_fault[r_ch] <= 1'b0;
                    end else if (r_wait_cnt == c_CNT_W'(WAIT_MAX - 1)) begin
                        r_fault[r_ch] <= 1'b1;
                        r_state       <= S_NEXT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
`endif
                    end
                end
                S_UPDATE: begin
                    r_lo[r_ch]     <= w_lo_nxt;
                    r_hi[r_ch]     <= w_hi_nxt;
                    r_iref[r_ch]   <= w_iref_nxt;
                    r_qlock[r_ch]  <= w_qlock_nxt;
                    r_locked[r_ch] <= w_locked_nxt;
                    r_state        <= S_NEXT;
                end
                S_NEXT: begin
                    r_ch <= w_ch_next;
                    if (enable) begin
                        r_state    <= S_REQ;
                        meas_start <= 1'b1;
                        meas_ch    <= w_ch_next;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign i_ref_out[g*BUS_WIDTH +: BUS_WIDTH] = r_iref[g];
        assign setup_completed[g]                  = r_locked[g];
    end

endmodule
`default_nettype wire

// File: tb/tb_q_track_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_q_track_ctrl
//  Description : Self-checking bench for q_track_ctrl with a behavioural
//                regulator model and a plant that answers measurement requests.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_q_track_ctrl;

    localparam int BW   = 10;
    localparam int NCH  = 4;
    localparam int WMAX = 20;
    localparam int QMAX = 1023;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [NCH*BW-1:0] q_desired;
    logic              meas_start;
    logic [1:0]        meas_ch;
    logic              ready;
    logic [BW-1:0]     q_measured;
    logic [NCH*BW-1:0] i_ref_out;
    logic [NCH-1:0]    setup_completed;
    logic [NCH-1:0]    fault;

    q_track_ctrl #(
        .BUS_WIDTH(BW), .NUM_CH(NCH), .TOL(1), .DELTA_Q_INSTB(50),
        .I_REF_DELTA_INSTB(10), .WAIT_MAX(WMAX)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .q_desired(q_desired),
        .meas_start(meas_start), .meas_ch(meas_ch), .ready(ready),
        .q_measured(q_measured), .i_ref_out(i_ref_out),
        .setup_completed(setup_completed), .fault(fault)
    );

    always #5 clk = ~clk;

    int m_lo[NCH], m_hi[NCH], m_iref[NCH], m_qlock[NCH], m_qd[NCH], m_off[NCH];
    bit m_lock[NCH], m_fault[NCH];
    int exp_ch;
    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic int clampq(input int x);
        return (x < 0) ? 0 : ((x > QMAX) ? QMAX : x);
    endfunction

    function automatic int dut_iref(input int c);
        return int'(i_ref_out[c*BW +: BW]);
    endfunction

    function automatic bit all_locked();
        for (int c = 0; c < NCH; c++) if (!m_lock[c]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_lo[c] = 0; m_hi[c] = QMAX; m_iref[c] = 512;
            m_lock[c] = 1'b0; m_qlock[c] = 0; m_fault[c] = 1'b0;
        end
        exp_ch = 0;
    endfunction

    // Regulator rules in plain integer arithmetic.
    function automatic void model_update(input int c, input int q);
        if (!m_lock[c]) begin
            if (iabs(q - m_qd[c]) <= 1) begin
                m_lock[c] = 1'b1; m_qlock[c] = q;
            end else begin
                if (q < m_qd[c]) m_lo[c] = m_iref[c];
                else             m_hi[c] = m_iref[c];
                if (m_hi[c] - m_lo[c] <= 1) begin
                    m_lock[c] = 1'b1; m_qlock[c] = q;
                end else begin
                    m_iref[c] = (m_lo[c] + m_hi[c]) / 2;
                end
            end
        end else if (iabs(q - m_qlock[c]) > 50) begin
            m_lock[c] = 1'b0;
            m_lo[c]   = (m_iref[c] - 10 < 0) ? 0 : m_iref[c] - 10;
            m_hi[c]   = (m_iref[c] + 10 > QMAX) ? QMAX : m_iref[c] + 10;
        end
    endfunction

    task automatic set_targets();
        for (int c = 0; c < NCH; c++) q_desired[c*BW +: BW] = BW'(m_qd[c]);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int c = 0; c < NCH; c++) begin
                chk($sformatf("i_ref_out[%0d]", c), dut_iref(c), m_iref[c]);
                chk($sformatf("setup_completed[%0d]", c), int'(setup_completed[c]), int'(m_lock[c]));
`ifdef Q_TRACK_TIMEOUT_EN
                chk($sformatf("fault[%0d]", c), int'(fault[c]), int'(m_fault[c]));
`else
                chk($sformatf("fault[%0d]", c), int'(fault[c]), 0);
`endif
            end
        end
    end

    // mode 1 pushes a locked channel's measurement 60 away from its lock value.
    task automatic visit(input bit have_start, input int mode, input bit s_req,
                         input bit s_next, input int dly);
        int  c;
        int  q;
        bit  got;
        c   = exp_ch;
        got = have_start;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (meas_start) got = 1'b1;
        end
        if (!got) begin
            chk("meas_start_seen", 0, 1);
            return;
        end
        chk("meas_ch", int'(meas_ch), c);
        if (s_req) begin
            ready = 1'b1; q_measured = BW'($urandom);
        end
        @(posedge clk); #1;
        ready = 1'b0;
        chk("meas_start_pulse", int'(meas_start), 0);
        repeat (dly) @(posedge clk);
        @(negedge clk);
        chk("meas_ch_stable", int'(meas_ch), c);
        q = clampq(m_iref[c] + m_off[c]);
        if (mode == 1 && m_lock[c])
            q = (m_qlock[c] + 60 <= QMAX) ? m_qlock[c] + 60 : m_qlock[c] - 60;
        ready = 1'b1; q_measured = BW'(q);
        @(posedge clk); #1;
        ready = 1'b0; q_measured = BW'($urandom);
        m_fault[c] = 1'b0;
        @(posedge clk); #1;
        model_update(c, q);
        exp_ch = (c + 1) % NCH;
        if (s_next) begin
            ready = 1'b1; q_measured = BW'($urandom);
            @(posedge clk); #1;
            ready = 1'b0;
        end
    endtask

    task automatic run_until_locked(input int max_visits);
        for (int i = 0; i < max_visits; i++) begin
            visit(1'b0, 0, 1'b0, 1'b0, int'($urandom_range(0, 3)));
            if (all_locked() && exp_ch == 0) break;
        end
        chk("all_locked", int'(all_locked()), 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; model_reset();
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_meas_start", int'(meas_start), 0);
        chk("rst_meas_ch", int'(meas_ch), 0);
        chk("rst_setup_completed", int'(setup_completed), 0);
        chk("rst_fault", int'(fault), 0);
        for (int c = 0; c < NCH; c++) chk("rst_i_ref_out", dut_iref(c), 512);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; ready = 1'b0; q_measured = '0;
        m_qd = '{100, 200, 300, 400};
        m_off = '{0, 0, 0, 0};
        set_targets();
        model_reset();
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0; enable = 1'b1;

        // Four independent targets, exact plant q = i_ref.
        run_until_locked(60);
        chk("ch0_i_ref_100", dut_iref(0), 100);
        chk("ch2_i_ref_300", dut_iref(2), 300);
        chk("ch1_within_tol", int'(iabs(dut_iref(1) - 200) <= 1), 1);
        chk("ch3_within_tol", int'(iabs(dut_iref(3) - 400) <= 1), 1);
        chk("setup_all", int'(setup_completed), 15);

        // Reset while waiting for a measurement, then a late ready must be ignored.
        begin
            bit got = 1'b0;
            for (int i = 0; i < 60 && !got; i++) begin
                @(negedge clk);
                if (meas_start) got = 1'b1;
            end
            chk("meas_start_seen", int'(got), 1);
            @(posedge clk); #1;
            @(negedge clk); rst = 1'b1;
            @(posedge clk); #1; model_reset(); enable = 1'b0;
            @(negedge clk);
            check_reset_outputs();
            rst = 1'b0;
            ready = 1'b1; q_measured = 10'd700;
            @(posedge clk); #1; ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                chk("idle_no_start", int'(meas_start), 0);
            end
        end

        // Lock at 512 / near both rails, then force instability on every channel.
        m_qd = '{512, 5, 1020, 700};
        set_targets();
        enable = 1'b1;
        run_until_locked(80);
        chk("ch0_lock_512", dut_iref(0), 512);
        for (int c = 0; c < NCH; c++) visit(1'b0, 1, 1'b0, 1'b0, 1);
        chk("model_lo_502", m_lo[0], 502);
        chk("model_hi_522", m_hi[0], 522);
        chk("model_lo_sat0", m_lo[1], 0);
        chk("model_hi_sat1023", m_hi[2], 1023);
        chk("unlocked_all", int'(setup_completed), 0);
        chk("ch0_i_ref_held", dut_iref(0), 512);
        run_until_locked(80);
        chk("relock_ch0_512", dut_iref(0), 512);

        // Randomized targets, plant offsets, delays, stray readies and disturbances.
        pulse_reset();
        for (int c = 0; c < NCH; c++) begin
            m_qd[c]  = int'($urandom_range(50, 950));
            m_off[c] = int'($urandom_range(0, 30)) - 15;
        end
        set_targets();
        for (int i = 0; i < 80; i++) begin
            bit pause;
            pause = (i == 40);
            visit(1'b0, ($urandom_range(0, 7) == 0) ? 1 : 0,
                  ($urandom_range(0, 3) == 0), !pause && ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 4)));
            if (pause) begin
                enable = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    @(negedge clk);
                    chk("paused_no_start", int'(meas_start), 0);
                end
                enable = 1'b1;
            end
        end

`ifdef Q_TRACK_TIMEOUT_EN
        // Withhold ready: channel faults and the loop advances; its next ready clears it.
        begin
            bit got = 1'b0;
            int c;
            int n = 0;
            chk_en = 1'b0;
            for (int i = 0; i < 60 && !got; i++) begin
                @(negedge clk);
                if (meas_start) got = 1'b1;
            end
            c = exp_ch;
            chk("to_meas_ch", int'(meas_ch), c);
            got = 1'b0;
            for (int i = 1; i <= WMAX + 10 && !got; i++) begin
                @(negedge clk);
                if (meas_start) begin
                    got = 1'b1; n = i;
                end
            end
            chk("to_restart_cycles", n, WMAX + 2);
            chk("to_next_ch", int'(meas_ch), (c + 1) % NCH);
            chk("to_fault_set", int'(fault[c]), 1);
            m_fault[c] = 1'b1;
            exp_ch = (c + 1) % NCH;
            chk_en = 1'b1;
            visit(1'b1, 0, 1'b0, 1'b0, 0);
            for (int k = 0; k < NCH - 1; k++) visit(1'b0, 0, 1'b0, 1'b0, 0);
            chk("to_fault_cleared", int'(fault[c]), 0);
        end
`endif

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        errors++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
